// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_EXT  = 2'd2
  } grant_t;

  localparam int STREAK_W = 8;
  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 32;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Two-way arbiter for the single-port data memory: CPU has priority, ext is forced in after a CPU streak.
// Grant and CPU read data are same-cycle; ext read data is registered (+1 cycle); losers stall or hold their request.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   stall_count
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  grant_t              gnt_sel;
  logic [STREAK_W-1:0] streak;

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (rst) begin
      if (cpu_req && (!ext_req || (streak < LIMIT)))
        gnt_sel = GNT_CPU;
      else if (ext_req)
        gnt_sel = GNT_EXT;
    end
  end

  assign cpu_gnt = (gnt_sel == GNT_CPU);
  assign ext_gnt = (gnt_sel == GNT_EXT);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt_sel)
      GNT_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GNT_EXT: begin
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign cpu_stall = rst & cpu_req & ~cpu_gnt;

  // Streak only measures CPU wins while ext is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      streak <= '0;
    else if (ext_gnt || !ext_req)
      streak <= '0;
    else if (cpu_gnt && (streak < LIMIT))
      streak <= streak + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we)
        ext_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_count <= '0;
    else if (cpu_stall && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end

endmodule
